// File: rtl/dff_stim_checker.sv
// Self-contained driver/checker for a single D flip-flop under test.
// Resets the DUT, drives an LFSR bit stream into its d input, compares
// q against a delayed copy of the driven stream and reports the result.
module dff_stim_checker #(
    parameter int         NUM_VECTORS = 64,
    parameter int         RST_CYCLES  = 2,
    parameter int         LATENCY     = 1,
    parameter logic [7:0] LFSR_SEED   = 8'hA5,
    parameter int         ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_rst_n,
    output logic             d_out,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [15:0]      first_err_idx
);

    // Out-of-range parameters stop elaboration.
    generate
        if (NUM_VECTORS < 1 || NUM_VECTORS > 65535) begin : g_bad_num_vectors
            $error("dff_stim_checker: NUM_VECTORS must be 1..65535");
        end
        if (RST_CYCLES < 2 || RST_CYCLES > 15) begin : g_bad_rst_cycles
            $error("dff_stim_checker: RST_CYCLES must be 2..15");
        end
        if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
            $error("dff_stim_checker: LATENCY must be 1..4");
        end
        if (ERR_W < 1 || ERR_W > 32) begin : g_bad_err_w
            $error("dff_stim_checker: ERR_W must be 1..32");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;

    // Stage 0 mirrors the bit currently on d_out; stage LATENCY is the
    // bit the DUT should be presenting on q_in at the next edge.
    localparam int             PIPE_D   = LATENCY + 1;
    localparam logic [7:0]     SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [15:0]    RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0]    NV       = 16'(NUM_VECTORS);
    localparam logic [15:0]    LAT_LAST = 16'(LATENCY - 1);
    localparam logic [15:0]    RST_IDX  = 16'hFFFF;

    state_e                  state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [7:0]              lfsr_q, lfsr_d, lfsr_next;
    logic                    d_out_q, d_out_d;
    logic                    dut_rst_n_q, dut_rst_n_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic [ERR_W-1:0]        err_q, err_d;
    logic [15:0]             first_q, first_d;
    logic [PIPE_D-1:0]       pipe_vld_q, pipe_vld_d;
    logic [PIPE_D-1:0]       pipe_bit_q, pipe_bit_d;
    logic [PIPE_D-1:0][15:0] pipe_idx_q, pipe_idx_d;

    logic                    err_hit;
    logic [15:0]             err_idx;
    logic                    drive_vec;
    logic [15:0]             vec_idx;
    logic                    launch;

    // x^8+x^6+x^5+x^4+1, shift left, feedback into the lsb.
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    // Next-state, check and datapath logic.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        lfsr_d      = lfsr_q;
        d_out_d     = d_out_q;
        dut_rst_n_d = dut_rst_n_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_d       = err_q;
        first_d     = first_q;
        err_hit     = 1'b0;
        err_idx     = pipe_idx_q[LATENCY];
        drive_vec   = 1'b0;
        vec_idx     = '0;
        launch      = 1'b0;

        // Reset check on the edge ending the last RST cycle; data check
        // whenever the oldest pipeline entry is valid.
        if (state_q == S_RST && cnt_q == RST_LAST) begin
            err_hit = q_in;
            err_idx = RST_IDX;
        end else if (pipe_vld_q[LATENCY]) begin
            err_hit = (q_in != pipe_bit_q[LATENCY]);
        end

        if (err_hit) begin
            if (err_q != ERR_MAX) begin
                err_d = err_q + 1'b1;
            end
            if (err_q == '0) begin
                first_d = err_idx;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    launch      = 1'b1;
                    state_d     = S_RST;
                    cnt_d       = '0;
                    lfsr_d      = SEED;
                    d_out_d     = 1'b0;
                    dut_rst_n_d = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_d       = '0;
                    first_d     = '0;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d     = S_RUN;
                    dut_rst_n_d = 1'b1;
                    drive_vec   = 1'b1;
                    vec_idx     = '0;
                    cnt_d       = 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RUN: begin
                if (cnt_q == NV) begin
                    state_d = S_DRAIN;
                    d_out_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    drive_vec = 1'b1;
                    vec_idx   = cnt_q;
                    cnt_d     = cnt_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (drive_vec) begin
            d_out_d = lfsr_q[7];
            lfsr_d  = lfsr_next;
        end

        pipe_vld_d = {pipe_vld_q[PIPE_D-2:0], drive_vec};
        pipe_bit_d = {pipe_bit_q[PIPE_D-2:0], drive_vec & lfsr_q[7]};
        pipe_idx_d = {pipe_idx_q[PIPE_D-2:0], vec_idx};
        if (launch) begin
            pipe_vld_d = '0;
        end
    end

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers, including the expectation pipeline, cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            lfsr_q      <= SEED;
            d_out_q     <= 1'b0;
            dut_rst_n_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_q       <= '0;
            first_q     <= '0;
            pipe_vld_q  <= '0;
            pipe_bit_q  <= '0;
            pipe_idx_q  <= '0;
        end else begin
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            d_out_q     <= d_out_d;
            dut_rst_n_q <= dut_rst_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_q       <= err_d;
            first_q     <= first_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_bit_q  <= pipe_bit_d;
            pipe_idx_q  <= pipe_idx_d;
        end
    end

    assign dut_rst_n     = dut_rst_n_q;
    assign d_out         = d_out_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_dff_stim_checker.sv
// Bench for dff_stim_checker: three checker instances (default, ERR_W=4,
// LATENCY=2) each wrapped around a behavioural flop model.
module tb_dff_stim_checker;

    localparam int N = 64;
    localparam int R = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, start4, start2, inj;
    bit   inv;

    logic       dut_rst_n, d_out, q_in, busy, done, pass;
    logic [7:0] err;
    logic [15:0] first;

    logic       dut_rst_n4, d_out4, q_in4, busy4, done4, pass4;
    logic [3:0] err4;
    logic [15:0] first4;

    logic       dut_rst_n2, d_out2, q_in2, busy2, done2, pass2;
    logic [7:0] err2;
    logic [15:0] first2;

    dff_stim_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_rst_n(dut_rst_n), .d_out(d_out),
        .q_in(q_in), .busy(busy), .done(done), .pass(pass), .err_count(err),
        .first_err_idx(first)
    );

    dff_stim_checker #(.ERR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dut_rst_n(dut_rst_n4), .d_out(d_out4),
        .q_in(q_in4), .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
        .first_err_idx(first4)
    );

    dff_stim_checker #(.LATENCY(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .dut_rst_n(dut_rst_n2), .d_out(d_out2),
        .q_in(q_in2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_idx(first2)
    );

    // Flops under test: golden (or inverting) flop, inverting flop, two-stage flop.
    logic qm = 1'b0, qm4 = 1'b0, s1 = 1'b0, s2 = 1'b0;
    always @(posedge clk) begin
        qm  <= inv ? ~d_out : (!dut_rst_n ? 1'b0 : d_out);
        qm4 <= ~d_out4;
        s1  <= !dut_rst_n2 ? 1'b0 : d_out2;
        s2  <= !dut_rst_n2 ? 1'b0 : s1;
    end
    assign q_in  = qm ^ inj;
    assign q_in4 = qm4;
    assign q_in2 = s2;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_bits[N];

    typedef struct {
        int pre;
        bit rst_bad;
        int flip_a;
        int flip_b;
        int exp_err;
        int exp_first;
        bit exp_pass;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full run on the default instance with per-vector q corruption.
    task automatic run_main(input int pre, input bit rst_bad, input bit mask[N],
                            input int exp_err, input int exp_first, input bit exp_pass);
        repeat (pre) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_busy", 32'(busy), 1);
        check("run_dut_rst", 32'(dut_rst_n), 0);
        check("run_done_clr", 32'(done), 0);
        check("run_err_clr", 32'(err), 0);
        check("run_first_clr", 32'(first), 0);
        repeat (R - 1) tick();
        check("rst_hold", 32'(dut_rst_n), 0);
        inj = rst_bad;
        tick();
        inj = 1'b0;
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                if (i == 0) check("rst_release", 32'(dut_rst_n), 1);
                check($sformatf("d_out[%0d]", i), 32'(d_out), 32'(exp_bits[i]));
            end else begin
                check("done_early", 32'(done), 0);
            end
            inj = (i >= 1) ? mask[i-1] : 1'b0;
            tick();
        end
        inj = 1'b0;
        check("done", 32'(done), 1);
        check("busy_end", 32'(busy), 0);
        check("err_count", 32'(err), 32'(exp_err));
        check("first_err_idx", 32'(first), 32'(exp_first));
        check("pass", 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        int s;
        int fb;
        bit m[N];
        int e;
        int f;
        int c;
        int c1;
        int c2;
        bit rb;

        // Expected stream straight from the polynomial and seed A5.
        s = 'hA5;
        for (int i = 0; i < N; i++) begin
            exp_bits[i] = bit'((s >> 7) & 1);
            fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
            s = ((s << 1) | fb) & 255;
        end

        tbl[0] = '{2, 1'b0, -1, -1, 0, 0,       1'b1};
        tbl[1] = '{0, 1'b0, 10, -1, 1, 10,      1'b0};
        tbl[2] = '{0, 1'b0, -1, -1, 0, 0,       1'b1};
        tbl[3] = '{1, 1'b1, -1, -1, 1, 'hFFFF,  1'b0};
        tbl[4] = '{0, 1'b0, 0,  63, 2, 0,       1'b0};
        tbl[5] = '{3, 1'b1, 5,  -1, 2, 'hFFFF,  1'b0};

        rst_n = 1'b0; start = 1'b0; start4 = 1'b0; start2 = 1'b0; inj = 1'b0; inv = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err", 32'(err), 0);
        check("rst_first", 32'(first), 0);
        check("rst_dut_rst_n", 32'(dut_rst_n), 1);
        check("rst_d_out", 32'(d_out), 0);
        rst_n = 1'b1;

        // Table-driven runs.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < N; i++) m[i] = (i == tbl[t].flip_a) || (i == tbl[t].flip_b);
            run_main(tbl[t].pre, tbl[t].rst_bad, m, tbl[t].exp_err, tbl[t].exp_first, tbl[t].exp_pass);
        end

        // Randomized corruption patterns against a counting model.
        for (int r = 0; r < 6; r++) begin
            rb = ($urandom_range(0, 3) == 0);
            e = rb ? 1 : 0;
            f = rb ? 'hFFFF : -1;
            for (int i = 0; i < N; i++) begin
                m[i] = ($urandom_range(0, 15) == 0);
                if (m[i]) begin
                    e++;
                    if (f < 0) f = i;
                end
            end
            if (f < 0) f = 0;
            if (e > 255) e = 255;
            run_main($urandom_range(0, 3), rb, m, e, f, e == 0);
        end

        // Inverting flop: reset check and all data checks fail.
        inv = 1'b1;
        for (int i = 0; i < N; i++) m[i] = 1'b0;
        run_main(1, 1'b0, m, 65, 'hFFFF, 1'b0);
        inv = 1'b0;

        // ERR_W=4 instance with inverting flop saturates at 15.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        c = 0;
        while (!done4 && c < 300) begin
            tick();
            c++;
        end
        check("w4_cycles", 32'(c), 67);
        check("w4_err_sat", 32'(err4), 15);
        check("w4_first", 32'(first4), 'hFFFF);
        check("w4_pass", 32'(pass4), 0);

        // LATENCY=2 finishes exactly one cycle after LATENCY=1.
        tick();
        start = 1'b1; start2 = 1'b1;
        tick();
        start = 1'b0; start2 = 1'b0;
        c1 = -1; c2 = -1;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (done && c1 < 0) c1 = k;
            if (done2 && c2 < 0) c2 = k;
            if (c1 >= 0 && c2 >= 0) break;
        end
        check("lat1_cycles", 32'(c1), 67);
        check("lat2_cycles", 32'(c2), 68);
        check("lat2_pass", 32'(pass2), 1);
        check("lat2_err", 32'(err2), 0);
        check("lat1_pass", 32'(pass), 1);

        // rst_n pulse at vector 20 after a stretch of injected errors.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (R + 5) tick();
        inj = 1'b1;
        repeat (15) tick();
        check("mid_d_out20", 32'(d_out), 32'(exp_bits[20]));
        check("mid_err_before", 32'(err), 15);
        check("mid_first_before", 32'(first), 4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        inj = 1'b0;
        check("mid_busy", 32'(busy), 0);
        check("mid_done", 32'(done), 0);
        check("mid_pass", 32'(pass), 0);
        check("mid_dut_rst_n", 32'(dut_rst_n), 1);
        check("mid_d_out", 32'(d_out), 0);
        check("mid_err", 32'(err), 0);
        check("mid_first", 32'(first), 0);
        tick();
        check("mid_idle_busy", 32'(busy), 0);

        // start pulses during RST and RUN are ignored.
        start = 1'b1;
        tick();
        c = 0;
        for (int k = 1; k <= 300; k++) begin
            start = (k == 2 || k == R + 10) ? 1'b1 : 1'b0;
            tick();
            c = k;
            if (done) break;
        end
        start = 1'b0;
        check("ign_cycles", 32'(c), 67);
        check("ign_pass", 32'(pass), 1);
        check("ign_err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
